// File: rtl/calendar_pkg.sv
// Shared constants and helpers for the calendar counter fields.
// Contents:
//   SEC_MAX, MIN_MAX, HOUR_MAX, MONTH_MAX, YEAR_MAX : per-field upper limits
//   DAY_MIN, MONTH_MIN                              : fields that start at 1
//   days_in_month(month, leap)                      : 28..31, drives a day counter's max_val
package calendar_pkg;

    localparam int unsigned SEC_MAX   = 59;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned HOUR_MAX  = 23;
    localparam int unsigned MONTH_MAX = 12;
    localparam int unsigned YEAR_MAX  = 99;
    localparam int unsigned DAY_MIN   = 1;
    localparam int unsigned MONTH_MIN = 1;

    // Month is 1..12; anything outside that range is treated as a 31-day month.
    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
        logic [4:0] days;
        case (month)
            4'd2:                      days = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   days = 5'd30;
            default:                   days = 5'd31;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/calendar_counter.sv
// Loadable up/down modulo counter usable for any calendar/clock field.
// Ports:
//   clk      in   rising-edge clock
//   clear    in   asynchronous active-high reset (count=RST_VAL, pulses cleared)
//   load     in   load request, takes priority over tick
//   data     in   value to load, accepted only within [MIN_VAL, limit]
//   tick     in   one count step per cycle while high
//   down     in   direction, 0 = up, 1 = down
//   max_val  in   runtime upper limit (clamped up to MIN_VAL)
//   read_en  in   gates count onto databus
//   count    out  registered value
//   databus  out  read_en ? count : 0 (combinational)
//   carry    out  one-cycle pulse on wrap (up max->MIN, down MIN->max)
//   load_err out  one-cycle pulse on a rejected load
module calendar_counter
    import calendar_pkg::*;
#(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             tick,
    input  logic             down,
    input  logic [WIDTH-1:0] max_val,
    input  logic             read_en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] databus,
    output logic             carry,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] lim;
    logic             data_ok;

    generate
        if (MIN_VAL == 0) begin : g_lim_zero
            assign lim = max_val;
        end else begin : g_lim_clamp
            assign lim = (max_val < MIN_W) ? MIN_W : max_val;
        end
    endgenerate

    // Range check as a single unsigned compare of offsets from MIN_VAL:
    // data below MIN_VAL wraps to a large offset and fails, and lim >= MIN_VAL always.
    assign data_ok = (data - MIN_W) <= (lim - MIN_W);

    assign databus = read_en ? count : '0;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count    <= RST_W;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (data_ok) begin
                    count <= data;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick) begin
                if (!down) begin
                    // >= also wraps a count left above a limit that just shrank
                    if (count >= lim) begin
                        count <= MIN_W;
                        carry <= 1'b1;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    if (count > lim) begin
                        count <= lim;
                    end else if (count == MIN_W) begin
                        count <= lim;
                        carry <= 1'b1;
                    end else begin
                        count <= count - WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_counter.sv
module tb_calendar_counter;
    import calendar_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- day counter (MIN_VAL=1, RST_VAL=1) ----------------
    logic       clr_d = 1'b0;
    logic       d_load = 1'b0, d_tick = 1'b0, d_down = 1'b0, d_rd = 1'b0;
    logic [5:0] d_data = '0, d_max = 6'd31;
    logic [5:0] d_count, d_bus;
    logic       d_carry, d_err;

    calendar_counter #(.WIDTH(6), .MIN_VAL(1), .RST_VAL(1)) u_day (
        .clk(clk), .clear(clr_d), .load(d_load), .data(d_data), .tick(d_tick),
        .down(d_down), .max_val(d_max), .read_en(d_rd), .count(d_count),
        .databus(d_bus), .carry(d_carry), .load_err(d_err)
    );

    // ---------------- sec -> min -> hour chain ----------------
    logic       clr_c = 1'b0;
    logic       s_load = 1'b0, m_load = 1'b0, h_load = 1'b0, s_tick = 1'b0;
    logic [5:0] s_data = '0, m_data = '0, h_data = '0;
    logic [5:0] s_max = 6'(SEC_MAX), m_max = 6'(MIN_MAX), h_max = 6'(HOUR_MAX);
    logic [5:0] s_count, m_count, h_count, s_bus, m_bus, h_bus;
    logic       s_carry, m_carry, h_carry, s_err, m_err, h_err;
    logic       c_down = 1'b0, c_rd = 1'b0;

    calendar_counter #(.WIDTH(6), .MIN_VAL(0), .RST_VAL(0)) u_sec (
        .clk(clk), .clear(clr_c), .load(s_load), .data(s_data), .tick(s_tick),
        .down(c_down), .max_val(s_max), .read_en(c_rd), .count(s_count),
        .databus(s_bus), .carry(s_carry), .load_err(s_err)
    );
    calendar_counter #(.WIDTH(6), .MIN_VAL(0), .RST_VAL(0)) u_min (
        .clk(clk), .clear(clr_c), .load(m_load), .data(m_data), .tick(s_carry),
        .down(c_down), .max_val(m_max), .read_en(c_rd), .count(m_count),
        .databus(m_bus), .carry(m_carry), .load_err(m_err)
    );
    calendar_counter #(.WIDTH(6), .MIN_VAL(0), .RST_VAL(0)) u_hour (
        .clk(clk), .clear(clr_c), .load(h_load), .data(h_data), .tick(m_carry),
        .down(c_down), .max_val(h_max), .read_en(c_rd), .count(h_count),
        .databus(h_bus), .carry(h_carry), .load_err(h_err)
    );

    // ---------------- directed vector table for the day counter ----------------
    typedef struct {
        logic       load;
        logic [5:0] data;
        logic       tick;
        logic       down;
        logic [5:0] maxv;
        logic       rd;
        logic [5:0] e_count;
        logic       e_carry;
        logic       e_err;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input int ld, input int dt, input int tk, input int dn,
                                input int mx, input int rd, input int ec, input int ecy,
                                input int eer);
        vec_t v;
        v.load = ld[0]; v.data = 6'(dt); v.tick = tk[0]; v.down = dn[0];
        v.maxv = 6'(mx); v.rd = rd[0]; v.e_count = 6'(ec); v.e_carry = ecy[0];
        v.e_err = eer[0];
        return v;
    endfunction

    // Behavioural model of one field: plain integer arithmetic on the rules.
    function automatic void model_step(input int minv, input int ld, input int dt,
                                       input int tk, input int dn, input int mx,
                                       inout int cnt, output int cy, output int er);
        int lim;
        lim = (mx < minv) ? minv : mx;
        cy = 0;
        er = 0;
        if (ld != 0) begin
            if (dt >= minv && dt <= lim) cnt = dt;
            else er = 1;
        end else if (tk != 0) begin
            if (dn == 0) begin
                if (cnt >= lim) begin cnt = minv; cy = 1; end
                else cnt = cnt + 1;
            end else begin
                if (cnt > lim) cnt = lim;
                else if (cnt == minv) begin cnt = lim; cy = 1; end
                else cnt = cnt - 1;
            end
        end
    endfunction

    initial begin
        int mc, mcy, mer;

        vecs[0]  = mk(1, 31, 0, 0, 31, 0, 31, 0, 0); // load 31
        vecs[1]  = mk(0,  0, 1, 0, 30, 0,  1, 1, 0); // limit shrank below count -> wrap
        vecs[2]  = mk(1, 32, 0, 0, 31, 0,  1, 0, 1); // out-of-range load rejected
        vecs[3]  = mk(0,  0, 0, 0, 31, 0,  1, 0, 0); // load_err is one cycle
        vecs[4]  = mk(1,  1, 0, 0, 12, 0,  1, 0, 0); // load 1
        vecs[5]  = mk(0,  0, 1, 1, 12, 0, 12, 1, 0); // borrow MIN -> max
        vecs[6]  = mk(0,  0, 1, 1, 12, 0, 11, 0, 0); // plain decrement
        vecs[7]  = mk(1, 12, 0, 0, 12, 0, 12, 0, 0); // park at wrap point
        vecs[8]  = mk(1,  7, 1, 0, 12, 0,  7, 0, 0); // load beats tick at wrap
        vecs[9]  = mk(1,  0, 0, 0, 12, 0,  7, 0, 1); // below MIN rejected
        vecs[10] = mk(0,  0, 0, 0,  5, 0,  7, 0, 0); // limit change alone holds count
        vecs[11] = mk(0,  0, 1, 1,  5, 0,  5, 0, 0); // down clamp, no carry
        vecs[12] = mk(0,  0, 1, 0,  0, 0,  1, 1, 0); // max_val below MIN -> lim=MIN
        vecs[13] = mk(0,  0, 0, 0, 31, 1,  1, 0, 0); // read_en exposes count

        // reset state
        clr_d = 1'b1; clr_c = 1'b1;
        #3;
        check("rst_day_count", d_count, 1);
        check("rst_day_carry", d_carry, 0);
        check("rst_day_err",   d_err,   0);
        check("rst_sec_count", s_count, 0);
        check("rst_sec_carry", s_carry, 0);
        @(negedge clk);
        clr_d = 1'b0; clr_c = 1'b0;

        // 60 ticks up on seconds: 0..59 then 0, carry only after 59->0
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); s_tick = 1'b1;
            @(posedge clk); #1;
            check("sec_up_count", s_count, (i + 1) % 60);
            check("sec_up_carry", s_carry, (i == 59) ? 1 : 0);
        end
        @(negedge clk); s_tick = 1'b0;
        @(posedge clk); #1;
        check("min_after_60", m_count, 1);

        // chain ripple 59:59:23 -> 0:0:0
        @(negedge clk);
        s_load = 1'b1; m_load = 1'b1; h_load = 1'b1;
        s_data = 6'd59; m_data = 6'd59; h_data = 6'd23;
        @(posedge clk); #1;
        check("chain_load_sec",  s_count, 59);
        check("chain_load_hour", h_count, 23);
        @(negedge clk);
        s_load = 1'b0; m_load = 1'b0; h_load = 1'b0; s_tick = 1'b1;
        @(posedge clk); #1;
        check("chain_c1_sec",   s_count, 0);
        check("chain_c1_scy",   s_carry, 1);
        check("chain_c1_min",   m_count, 59);
        check("chain_c1_bus",   s_bus,   0);
        @(negedge clk); s_tick = 1'b0;
        @(posedge clk); #1;
        check("chain_c2_min",   m_count, 0);
        check("chain_c2_mcy",   m_carry, 1);
        check("chain_c2_hour",  h_count, 23);
        check("chain_c2_bus",   m_bus,   0);
        @(posedge clk); #1;
        check("chain_c3_hour",  h_count, 0);
        check("chain_c3_hcy",   h_carry, 1);
        check("chain_c3_mcy",   m_carry, 0);
        check("chain_c3_bus",   h_bus,   0);
        @(posedge clk); #1;
        check("chain_c4_hcy",   h_carry, 0);

        // async clear mid-operation
        @(negedge clk); s_load = 1'b1; s_data = 6'd40;
        @(posedge clk);
        @(negedge clk); s_load = 1'b0; s_tick = 1'b1;
        @(posedge clk); #1;
        check("clr_pre_count", s_count, 41);
        #2 clr_c = 1'b1;
        #1;
        check("clr_async_count", s_count, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("clr_hold_count", s_count, 0);
        end
        @(negedge clk); clr_c = 1'b0;
        @(posedge clk); #1;
        check("clr_release_tick", s_count, 1);
        @(negedge clk); s_tick = 1'b0;

        // directed table on the day counter
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            d_load = vecs[i].load; d_data = vecs[i].data; d_tick = vecs[i].tick;
            d_down = vecs[i].down; d_max = vecs[i].maxv; d_rd = vecs[i].rd;
            @(posedge clk); #1;
            check($sformatf("vec%0d_count", i), d_count, vecs[i].e_count);
            check($sformatf("vec%0d_carry", i), d_carry, vecs[i].e_carry);
            check($sformatf("vec%0d_err",   i), d_err,   vecs[i].e_err);
            check($sformatf("vec%0d_bus",   i), d_bus,   vecs[i].rd ? int'(vecs[i].e_count) : 0);
        end

        // randomized run on the day counter against the model
        @(negedge clk);
        d_load = 1'b0; d_tick = 1'b0;
        clr_d = 1'b1;
        #1 clr_d = 1'b0;
        mc = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            d_load = ($urandom_range(0, 7) == 0);
            d_data = 6'($urandom_range(0, 63));
            d_tick = ($urandom_range(0, 1) == 1);
            d_down = ($urandom_range(0, 2) == 0);
            d_rd   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0)
                d_max = 6'($urandom_range(0, 63));
            else if ($urandom_range(0, 9) == 0)
                d_max = 6'(days_in_month(4'($urandom_range(1, 12)), 1'($urandom_range(0, 1))));
            @(posedge clk);
            model_step(1, d_load, d_data, d_tick, d_down, d_max, mc, mcy, mer);
            #1;
            check("rand_count", d_count, mc);
            check("rand_carry", d_carry, mcy);
            check("rand_err",   d_err,   mer);
            check("rand_bus",   d_bus,   d_rd ? mc : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
